// File: rtl/branch_cmp_arbiter_pkg.sv
// Shared definitions for the branch/SLT comparator arbiter: widths, funct3 codes,
// FSM encoding and requester ids.
package branch_cmp_arbiter_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic OWNER_BR  = 1'b0;
  localparam logic OWNER_SLT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } stateT;

  // The two unused codes in the branch space (010, 011) are reported as illegal.
  function automatic logic isIllegalF3(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_cmp_arbiter_branch.sv
// Combinational branch comparator: equality plus signed/unsigned less-than.
module branch #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  input  logic            BrUn,
  output logic            BrEq,
  output logic            BrLt
);

  assign BrEq = (dataA == dataB);
  assign BrLt = BrUn ? (dataA < dataB) : ($signed(dataA) < $signed(dataB));

endmodule

// File: rtl/branch_cmp_arbiter.sv
// Round-robin sharing of one branch comparator between branch resolution (req0)
// and SLT/SLTU (req1), with registered responses and a completed-compare counter.
module branch_cmp_arbiter
  import branch_cmp_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [2:0]       req0_funct3,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp0_taken,
  output logic             rsp0_illegal,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic             req1_unsigned,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic             rsp1_lt,
  output logic [CNT_W-1:0] cmp_count
);

  stateT           state;
  logic            lastGrant;
  logic            owner;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic [2:0]      opF3;
  logic            opUns;

  logic            grant;
  logic            anyValid;
  logic            brUn;
  logic            brEq;
  logic            brLt;
  logic            taken;

  // On a tie the requester that did not win last time gets the comparator.
  always_comb begin
    anyValid = req0_valid || req1_valid;
    grant    = OWNER_BR;
    if (req0_valid && req1_valid) begin
      grant = ~lastGrant;
    end else if (req1_valid) begin
      grant = OWNER_SLT;
    end
  end

  assign req0_ready = !rst && (state == IDLE) && anyValid && (grant == OWNER_BR);
  assign req1_ready = !rst && (state == IDLE) && anyValid && (grant == OWNER_SLT);

  assign brUn = (owner == OWNER_SLT) ? opUns : opF3[1];

  branch #(
    .XLEN(XLEN)
  ) uBranch (
    .dataA(opA),
    .dataB(opB),
    .BrUn (brUn),
    .BrEq (brEq),
    .BrLt (brLt)
  );

  always_comb begin
    taken = 1'b0;
    case (opF3)
      F3_BEQ:           taken = brEq;
      F3_BNE:           taken = !brEq;
      F3_BLT, F3_BLTU:  taken = brLt;
      F3_BGE, F3_BGEU:  taken = !brLt;
      default:          taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lastGrant    <= OWNER_SLT;
      owner        <= OWNER_BR;
      opA          <= '0;
      opB          <= '0;
      opF3         <= '0;
      opUns        <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_taken   <= 1'b0;
      rsp0_illegal <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_lt      <= 1'b0;
      cmp_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            owner     <= grant;
            lastGrant <= grant;
            if (grant == OWNER_SLT) begin
              opA   <= req1_a;
              opB   <= req1_b;
              opUns <= req1_unsigned;
            end else begin
              opA  <= req0_a;
              opB  <= req0_b;
              opF3 <= req0_funct3;
            end
            state <= CMP;
          end
        end
        CMP: begin
          if (owner == OWNER_SLT) begin
            rsp1_lt    <= brLt;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_taken   <= taken;
            rsp0_illegal <= isIllegalF3(opF3);
            rsp0_valid   <= 1'b1;
          end
          cmp_count <= cmp_count + 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's consumer can release the comparator.
          if ((owner == OWNER_BR) && rsp0_ready) begin
            rsp0_valid <= 1'b0;
            state      <= IDLE;
          end else if ((owner == OWNER_SLT) && rsp1_ready) begin
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
// Bench for branch_cmp_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_branch_cmp_arbiter;
  import branch_cmp_arbiter_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid, rsp0_ready, rsp1_ready, req1_unsigned;
  logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]      req0_funct3;
  logic            req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic            rsp0_taken, rsp0_illegal, rsp1_lt;
  logic [15:0]     cmp_count;
  logic            req0_ready2, req1_ready2, rsp0_valid2, rsp1_valid2;
  logic            rsp0_taken2, rsp0_illegal2, rsp1_lt2;
  logic [1:0]      cmp_count2;

  branch_cmp_arbiter #(.XLEN(XLEN), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct3(req0_funct3), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_taken(rsp0_taken), .rsp0_illegal(rsp0_illegal),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_unsigned(req1_unsigned), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_lt(rsp1_lt), .cmp_count(cmp_count)
  );

  // Narrow-counter copy fed the same stimulus, to exercise counter wrap.
  branch_cmp_arbiter #(.XLEN(XLEN), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready2), .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct3(req0_funct3), .rsp0_valid(rsp0_valid2), .rsp0_ready(rsp0_ready),
    .rsp0_taken(rsp0_taken2), .rsp0_illegal(rsp0_illegal2),
    .req1_valid(req1_valid), .req1_ready(req1_ready2), .req1_a(req1_a), .req1_b(req1_b),
    .req1_unsigned(req1_unsigned), .rsp1_valid(rsp1_valid2), .rsp1_ready(rsp1_ready),
    .rsp1_lt(rsp1_lt2), .cmp_count(cmp_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic [2:0]  f3;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic        expRes;
    logic        expIll;
  } vecT;

  vecT vecs[12];
  int  compared = 0;
  int  mismatched = 0;
  int  expCount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic chkCount(input string name);
    chk({name, "_count"}, 32'(cmp_count), 32'(expCount % 65536));
    chk({name, "_count_w2"}, 32'(cmp_count2), 32'(expCount % 4));
  endtask

  function automatic logic refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic refLt(input logic uns, input logic [31:0] a, input logic [31:0] b);
    return uns ? (a < b) : ($signed(a) < $signed(b));
  endfunction

  function automatic logic [31:0] pickB(input logic [31:0] a);
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return a;
    if (r == 1) return ~a;
    return $urandom;
  endfunction

  task automatic waitReady(input logic which, input string name, output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!(which ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (which ? req1_ready : req0_ready);
    if (!ok) timeoutFail(name);
  endtask

  task automatic runVec(input int idx);
    logic ok;
    vecT  v;
    v = vecs[idx];
    @(posedge clk); #1;
    if (v.owner) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_unsigned = v.uns;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_funct3 = v.f3;
    end
    waitReady(v.owner, "vec_accept", ok);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("vec_valid_early", 32'(v.owner ? rsp1_valid : rsp0_valid), 32'(0));
    @(negedge clk);
    expCount++;
    chk("vec_valid", 32'(v.owner ? rsp1_valid : rsp0_valid), 32'(1));
    chk("vec_other_valid", 32'(v.owner ? rsp0_valid : rsp1_valid), 32'(0));
    if (v.owner) begin
      chk("vec_lt", 32'(rsp1_lt), 32'(v.expRes));
    end else begin
      chk("vec_taken", 32'(rsp0_taken), 32'(v.expRes));
      chk("vec_illegal", 32'(rsp0_illegal), 32'(v.expIll));
    end
    chkCount("vec");
    $display("vec %0d owner=%0d f3=%0d uns=%0d a=%08h b=%08h result=%0d", idx, v.owner, v.f3, v.uns,
             v.a, v.b, v.owner ? rsp1_lt : rsp0_taken);
  endtask

  initial begin
    logic        ok;
    logic        busy, mOwner, mRes, mIll, lastG, drop0, drop1, g0, g1, busyNow;
    int          age, resps, n, txns;
    int          grants[$];

    vecs[0]  = '{1'b0, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 32'h5, 32'h5, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'd1, 1'b0, 32'h5, 32'h5, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'd3, 1'b0, 32'h5, 32'h5, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 3'd2, 1'b0, 32'h1, 32'h2, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 3'd5, 1'b0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd7, 1'b0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 3'd0, 1'b0, 32'h5, 32'hA, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 3'd0, 1'b1, 32'h7, 32'h7, 1'b0, 1'b0};

    // Reset with both requesters asserting, then round-robin alternation.
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1; req0_funct3 = 3'd4;
    req1_valid = 1'b1; req1_a = 32'h5; req1_b = 32'hA; req1_unsigned = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_req0_ready", 32'(req0_ready), 32'(0));
      chk("rst_req1_ready", 32'(req1_ready), 32'(0));
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'(0));
      chkCount("rst");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    resps = 0;
    n = 0;
    while (resps < 4 && n < 60) begin
      @(negedge clk);
      n++;
      chk("arb_exclusive", 32'(req0_ready && req1_ready), 32'(0));
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp0_valid) begin
        resps++; expCount++;
        chk("arb_taken", 32'(rsp0_taken), 32'(1));
      end
      if (rsp1_valid) begin
        resps++; expCount++;
        chk("arb_lt", 32'(rsp1_lt), 32'(1));
      end
    end
    if (resps < 4) timeoutFail("arb_responses");
    chk("arb_grant_count", 32'(grants.size()), 32'(4));
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      chk("arb_grant_order", 32'(grants[i]), 32'(i % 2));
      $display("arb txn %0d granted to req%0d", i, grants[i]);
    end
    chkCount("arb");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    for (int i = 0; i < 12; i++) runVec(i);

    // Backpressure on the SLT response while a branch request waits.
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'h1; req1_unsigned = 1'b0;
    waitReady(1'b1, "bp_accept", ok);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h9; req0_b = 32'h9; req0_funct3 = 3'd0;
    n = 0;
    @(negedge clk);
    while (!rsp1_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!rsp1_valid) timeoutFail("bp_rsp1_valid");
    expCount++;
    chkCount("bp");
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp1_valid), 32'(1));
      chk("bp_hold_lt", 32'(rsp1_lt), 32'(1));
      chk("bp_req0_blocked", 32'(req0_ready), 32'(0));
      chk("bp_rsp0_quiet", 32'(rsp0_valid), 32'(0));
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    chk("bp_hold_last", 32'(rsp1_valid), 32'(1));
    @(negedge clk);
    chk("bp_released", 32'(rsp1_valid), 32'(0));
    chk("bp_req0_grant", 32'(req0_ready), 32'(1));
    $display("bp txn slt lt=1 released, req0 accepted");
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expCount++;
    chk("bp_rsp0_valid", 32'(rsp0_valid), 32'(1));
    chk("bp_rsp0_taken", 32'(rsp0_taken), 32'(1));
    chkCount("bp_after");

    // Randomized traffic against a transaction-level model.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expCount = 0;
    busy = 1'b0; mOwner = 1'b0; mRes = 1'b0; mIll = 1'b0; lastG = 1'b1;
    drop0 = 1'b0; drop1 = 1'b0; age = 0; txns = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (drop0) begin req0_valid = 1'b0; drop0 = 1'b0; end
      if (drop1) begin req1_valid = 1'b0; drop1 = 1'b0; end
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1; req0_a = $urandom; req0_b = pickB(req0_a);
        req0_funct3 = 3'($urandom_range(0, 7));
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1; req1_a = $urandom; req1_b = pickB(req1_a);
        req1_unsigned = 1'($urandom_range(0, 1));
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      #1;
      busyNow = busy;
      if (busy) begin
        age++;
        if (age == 1) begin
          chk("rnd_valid_early0", 32'(rsp0_valid), 32'(0));
          chk("rnd_valid_early1", 32'(rsp1_valid), 32'(0));
        end else begin
          if (age == 2) expCount++;
          chk("rnd_owner_valid", 32'(mOwner ? rsp1_valid : rsp0_valid), 32'(1));
          chk("rnd_other_valid", 32'(mOwner ? rsp0_valid : rsp1_valid), 32'(0));
          if (mOwner) begin
            chk("rnd_lt", 32'(rsp1_lt), 32'(mRes));
          end else begin
            chk("rnd_taken", 32'(rsp0_taken), 32'(mRes));
            chk("rnd_illegal", 32'(rsp0_illegal), 32'(mIll));
          end
          if (mOwner ? rsp1_ready : rsp0_ready) begin
            busy = 1'b0;
            txns++;
            $display("rnd txn %0d owner=%0d result=%0d illegal=%0d", txns, mOwner, mRes, mIll);
          end
        end
      end else begin
        chk("rnd_idle_valid", 32'(rsp0_valid || rsp1_valid), 32'(0));
      end
      chkCount("rnd");
      g0 = !busyNow && req0_valid && (!req1_valid || lastG == 1'b1);
      g1 = !busyNow && req1_valid && (!req0_valid || lastG == 1'b0);
      chk("rnd_ready0", 32'(req0_ready), 32'(g0));
      chk("rnd_ready1", 32'(req1_ready), 32'(g1));
      if (g0 || g1) begin
        busy = 1'b1;
        age = 0;
        mOwner = g1;
        lastG = g1;
        if (g1) begin
          mRes = refLt(req1_unsigned, req1_a, req1_b);
          mIll = 1'b0;
          drop1 = 1'b1;
        end else begin
          mRes = refTaken(req0_funct3, req0_a, req0_b);
          mIll = (req0_funct3 == 3'd2) || (req0_funct3 == 3'd3);
          drop0 = 1'b1;
        end
      end
    end

    // Drain, then reset while a compare is in flight.
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h1; req0_funct3 = 3'd0;
    waitReady(1'b0, "rstcmp_accept", ok);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expCount = 0;
    repeat (6) begin
      @(negedge clk);
      chk("rstcmp_rsp0_valid", 32'(rsp0_valid), 32'(0));
      chk("rstcmp_rsp1_valid", 32'(rsp1_valid), 32'(0));
      chkCount("rstcmp");
    end
    $display("rstcmp txn dropped by reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
